// File: rtl/alu_seq_if.sv
// Bus bundle for alu_seq: instruction handshake, load port, ALU stub and result.
// ALU_SEQ_ZERO_FLAG_EN adds the zero result flag to the bundle.
interface alu_seq_if #(
  parameter int ALU_OPW = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [ALU_OPW-1:0] in_op;
  logic [1:0]         in_rd;
  logic [1:0]         in_ra;
  logic [1:0]         in_rb;
  logic               ld_en;
  logic [1:0]         ld_addr;
  logic [7:0]         ld_data;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [ALU_OPW-1:0] alu_sel;
  logic [7:0]         alu_o;
  logic               alu_cout;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic               zero;

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, ld_en, ld_addr, ld_data, alu_o, alu_cout,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry, zero
  );
  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, ld_en, ld_addr, ld_data, alu_o, alu_cout,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry, zero
  );
`else
  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, ld_en, ld_addr, ld_data, alu_o, alu_cout,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry
  );
  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, ld_en, ld_addr, ld_data, alu_o, alu_cout,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Four-state sequencer driving an external combinational ALU from a 4x8 register file.
// Optional zero result flag enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_seq #(
  parameter int ALU_OPW = 5
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]         r_state;
  logic [ALU_OPW-1:0] r_op;
  logic [1:0]         r_rd;
  logic [1:0]         r_ra;
  logic [1:0]         r_rb;
  logic [7:0]         r_rf [4];
  logic               r_carry;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [ALU_OPW-1:0] r_alu_sel;
  logic [7:0]         r_res;
  logic               r_res_c;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               w_ready;
  logic               w_accept;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic               r_zero;
`endif

  // A pending load blocks instruction acceptance for that cycle.
  assign w_ready  = (r_state == S_IDLE) & ~bus.ld_en & ~rst;
  assign w_accept = bus.in_valid & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_carry     <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res       <= '0;
      r_res_c     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ld_en) begin
            r_rf[bus.ld_addr] <= bus.ld_data;
          end else if (w_accept) begin
            r_op    <= bus.in_op;
            r_rd    <= bus.in_rd;
            r_ra    <= bus.in_ra;
            r_rb    <= bus.in_rb;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_alu_a   <= r_rf[r_ra];
          r_alu_b   <= r_rf[r_rb];
          r_alu_sel <= r_op;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_res   <= bus.alu_o;
          r_res_c <= bus.alu_cout;
          r_state <= S_WB;
        end
        default: begin
          // Sources were sampled in READ, so rd may alias ra/rb safely here.
          r_rf[r_rd]  <= r_res;
          r_carry     <= r_res_c;
          r_out_valid <= 1'b1;
          r_out_data  <= r_res;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          r_zero      <= (r_res == 8'h00);
`endif
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  // The carry flag and the reported carry change together in WB and hold otherwise.
  assign bus.out_carry = r_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.zero      = r_zero;
`endif

endmodule
